// File: rtl/tff_seq_ctrl.sv
// Sequencing controller for a bank of WIDTH T flip-flops: modulo up/down count, load, hold.
// Define TFF_SEQ_TC_STICKY_EN to make tc sticky until the next accepted start.
module tff_seq_ctrl #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STEP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              dir,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [WIDTH-1:0]  mod_val,
   input  logic [STEP_W-1:0] steps,
   output logic [WIDTH-1:0]  T_vec,
   output logic [WIDTH-1:0]  Q,
   output logic              busy,
   output logic              done,
   output logic              tc
);

   typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]    q_q;
   logic                tc_q, tc_d;

   logic [WIDTH-1:0]    top_val;
   logic [WIDTH-1:0]    up_t, dn_t, step_t;
   logic                up_c, dn_c;
   logic                up_wrap, dn_wrap, wrap;
   logic                count, start_acc;

   // mod_val == 0 underflows to all-ones, which is exactly 2^WIDTH - 1.
   assign top_val = mod_val - WIDTH'(1);

   // Ripple-carry style toggle enables for a plain +1 / -1 step.
   always_comb begin
      up_t = '0;
      dn_t = '0;
      up_c = 1'b1;
      dn_c = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         up_t[i] = up_c;
         dn_t[i] = dn_c;
         up_c    = up_c & q_q[i];
         dn_c    = dn_c & ~q_q[i];
      end
   end

   assign up_wrap = (q_q >= top_val);
   assign dn_wrap = (q_q == '0);
   assign wrap    = dir ? up_wrap : dn_wrap;
   assign step_t  = dir ? (up_wrap ? q_q : up_t) : (dn_wrap ? top_val : dn_t);

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      T_vec     = '0;
      count     = 1'b0;
      start_acc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               T_vec = q_q ^ load_val;
            end
            if (start) begin
               start_acc = 1'b1;
               if (steps != '0) begin
                  rem_d   = steps;
                  state_d = StRun;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRun: begin
            T_vec = step_t;
            count = 1'b1;
            rem_d = rem_q - STEP_W'(1);
            // The final step ends the run even if stop arrives with it.
            if (rem_q == STEP_W'(1)) begin
               state_d = StDone;
            end else if (stop) begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (start && !stop) begin
               state_d = StRun;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

`ifdef TFF_SEQ_TC_STICKY_EN
   always_comb begin
      tc_d = tc_q;
      if (start_acc) begin
         tc_d = 1'b0;
      end else if (count && wrap) begin
         tc_d = 1'b1;
      end
   end
`else
   always_comb begin
      tc_d = count && wrap;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rem_q   <= '0;
         q_q     <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         q_q     <= q_q ^ T_vec;
         tc_q    <= tc_d;
      end
   end

   assign Q    = q_q;
   assign busy = (state_q == StRun) || (state_q == StHold);
   assign done = (state_q == StDone);
   assign tc   = tc_q;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Scoreboard bench for tff_seq_ctrl: expected Q/busy/done/tc queued per cycle, compared after each edge.
module tb_tff_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, dir, load;
   logic [3:0] load_val, mod_val;
   logic [7:0] steps;
   logic [3:0] T_vec, Q;
   logic       busy, done, tc;

   typedef struct packed {
      logic [3:0] q;
      logic       busy;
      logic       done;
      logic       tc;
   } exp_t;

   exp_t       sb[$];
   int         n_chk = 0;
   int         n_fail = 0;
   logic [3:0] m_q;
   logic       m_tc;

   tff_seq_ctrl #(.WIDTH(4), .STEP_W(8)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .mod_val  (mod_val),
      .steps    (steps),
      .T_vec    (T_vec),
      .Q        (Q),
      .busy     (busy),
      .done     (done),
      .tc       (tc)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_next(input logic [3:0] q, input logic d,
                                             input logic [3:0] mv);
      int m  = (mv == 4'd0) ? 16 : int'(mv);
      int qi = int'(q);
      if (d) return (qi >= m - 1) ? 4'd0 : 4'(qi + 1);
      return (qi == 0) ? 4'(m - 1) : 4'(qi - 1);
   endfunction

   function automatic logic model_wrap(input logic [3:0] q, input logic d, input logic [3:0] mv);
      int m = (mv == 4'd0) ? 16 : int'(mv);
      return d ? (int'(q) >= m - 1) : (q == 4'd0);
   endfunction

   // One cycle of stimulus, entered and left on a falling edge.
   task automatic drive(input logic st, input logic sp, input logic ld, input logic [3:0] lv,
                        input logic ld_ok, input logic acc, input logic cnt,
                        input logic e_busy, input logic e_done);
      exp_t e;
      logic w;
      start    = st;
      stop     = sp;
      load     = ld;
      load_val = lv;
      w = cnt && model_wrap(m_q, dir, mod_val);
      if (ld_ok) m_q = lv;
      else if (cnt) m_q = model_next(m_q, dir, mod_val);
`ifdef TFF_SEQ_TC_STICKY_EN
      if (acc) m_tc = 1'b0;
      if (w) m_tc = 1'b1;
`else
      m_tc = w;
      if (acc) m_tc = 1'b0;
`endif
      e.q    = m_q;
      e.busy = e_busy;
      e.done = e_done;
      e.tc   = m_tc;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic run_n(input int n);
      steps = 8'(n);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, n != 0, n == 0);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, i < n - 1, i == n - 1);
      end
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load_q(input logic [3:0] v);
      drive(1'b0, 1'b0, 1'b1, v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("q", 32'(Q), 32'(e.q));
            check_eq("busy", 32'(busy), 32'(e.busy));
            check_eq("done", 32'(done), 32'(e.done));
            check_eq("tc", 32'(tc), 32'(e.tc));
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1; load = 1'b0;
      load_val = 4'd0; mod_val = 4'd0; steps = 8'd0;
      m_q = 4'd0; m_tc = 1'b0;
      #12;
      check_eq("rst_q", 32'(Q), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_tc", 32'(tc), 32'd0);
      check_eq("rst_tvec", 32'(T_vec), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Load 7, count up modulo 10: 8,9,0,1,2
      mod_val = 4'd10; dir = 1'b1;
      load_q(4'd7);
      run_n(5);

      // Down from 0 modulo 10: 9,8,7
      load_q(4'd0);
      dir = 1'b0;
      run_n(3);

      // Full range from 15: 0,1; then a zero-step run
      mod_val = 4'd0; dir = 1'b1;
      load_q(4'd15);
      run_n(2);
      run_n(0);

      // Load and start on the same edge: 3 then 4,5
      steps = 8'd2;
      drive(1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Pause and resume, 6 steps from 0
      load_q(4'd0);
      steps = 8'd6;
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      load = 1'b1; load_val = 4'd5; stop = 1'b0;
      #1;
      check_eq("hold_tvec", 32'(T_vec), 32'd0);
      drive(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, i < 3, i == 3);
      end
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("pause_final_q", 32'(Q), 32'd6);

      // Asynchronous reset in the middle of a run
      steps = 8'd5;
      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("arst_q", 32'(Q), 32'd0);
      check_eq("arst_busy", 32'(busy), 32'd0);
      check_eq("arst_done", 32'(done), 32'd0);
      check_eq("arst_tc", 32'(tc), 32'd0);
      check_eq("arst_tvec", 32'(T_vec), 32'd0);
      sb.delete();
      m_q = 4'd0; m_tc = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      run_n(3);

      // Wrap from 9 modulo 10, then idle cycles and a fresh start
      mod_val = 4'd10; dir = 1'b1;
      load_q(4'd9);
      run_n(3);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_n(0);

      @(posedge clk);
      #2;
      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/tff_seq_ctrl.md
Name: tff_seq_ctrl

Overview:
- Sequencing controller for a bank of WIDTH T flip-flops.
- Computes the per-bit toggle enables (T_vec) every cycle so the bank counts up or down modulo a programmable value, loads an arbitrary value, or holds.
- Runs a requested number of steps under a start/stop/done handshake.
- The flip-flop bank (Q <= Q ^ T_vec) is instantiated inside the block and exposed on Q.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank.
- STEP_W, 8, width of the step-count request and the internal remaining-steps counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin run (IDLE), or resume (HOLD)
- stop  input  1  pause a run (RUN -> HOLD)
- dir  input  1  1 = count up, 0 = count down; sampled every RUN cycle
- load  input  1  load load_val into the bank; honoured in IDLE only
- load_val  input  WIDTH  value to load
- mod_val  input  WIDTH  count modulus; 0 means 2^WIDTH
- steps  input  STEP_W  number of count steps per run; sampled when start is accepted
- T_vec  output  WIDTH  toggle enables applied to the bank (combinational from state, Q, dir, load)
- Q  output  WIDTH  bank state
- busy  output  1  high in RUN or HOLD
- done  output  1  one-cycle pulse at end of run
- tc  output  1  terminal-count indication (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous):
  - Q=0, state=IDLE, remaining=0.
  - busy=0, done=0, tc=0, T_vec=0.
- States: IDLE, RUN, HOLD, DONE.
- Bank update: every rising edge, Q <= Q ^ T_vec. The bank never changes by any other path.
- T_vec by state:
  - IDLE with load=1: T_vec = Q ^ load_val, so Q = load_val after the edge.
  - IDLE with load=0, and HOLD, DONE: T_vec = 0.
  - RUN: one count step per cycle, as below.
- Step rule, M = (mod_val==0) ? 2^WIDTH : mod_val:
  - Up: if Q >= M-1, T_vec = Q (wrap to 0). Otherwise T[0]=1 and T[i] = &Q[i-1:0].
  - Down: if Q == 0, T_vec = M-1 (load M-1). Otherwise T[0]=1 and T[i] = &~Q[i-1:0].
  - Loaded values >= M wrap to 0 on the next up step.
- IDLE:
  - start=1 and steps!=0: remaining <= steps, go RUN.
  - start=1 and steps==0: go DONE with no count.
  - stop is ignored.
  - load and start together: load is applied and start is accepted on the same edge, so counting begins from load_val.
- RUN:
  - stop=1: go HOLD. That cycle still counts; stop wins over a simultaneous start.
  - Otherwise each edge decrements remaining; at remaining==1 go DONE.
  - start and load are ignored.
- HOLD:
  - T_vec=0, remaining is frozen.
  - start=1 and stop=0: return to RUN.
  - load is ignored.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Timing: start accepted at edge k; Q changes at edges k+1 .. k+N for steps=N; done high between edges k+N and k+N+1.
- busy is registered-state derived: it rises the cycle after start is accepted and falls when DONE is entered.
- tc is asserted on any step that wraps (up Q>=M-1 -> 0, or down 0 -> M-1). It is visible the cycle after the wrapping edge.
- Asynchronous reset mid-run returns everything to reset values immediately; no done pulse is produced.
- dir changes mid-run take effect on the next step.

Optional Feature:
- Macro: TFF_SEQ_TC_STICKY_EN.
- Defined: tc is sticky. It is set by any wrap and held until the next accepted start, which clears it on the same edge.
- Undefined: tc is a one-cycle pulse, high only for the cycle following each wrapping edge.

Test Plan:
- All tests use WIDTH=4 and STEP_W=8.
- Load and count up: IDLE load=1 load_val=7; then mod_val=10, dir=1, start with steps=5 -> Q sequence 8,9,0,1,2. tc pulses once after the 9->0 edge. busy high 5 cycles, done pulses once, final Q=2.
- Down wrap: Q=0, mod_val=10, dir=0, steps=3 -> Q 9,8,7. tc pulses after the 0->9 edge.
- Full range: mod_val=0, Q=15, dir=1, steps=2 -> Q 0,1; tc pulses once. Also steps=0 -> no Q change, busy stays 0, done pulses one cycle after start.
- Pause and resume: steps=6 up from 0, mod_val=0; stop after 2 counts -> Q holds at the stop value, T_vec=0, busy=1. Load pulse in HOLD -> Q unchanged. Start -> remaining counts resume; final Q=6, done once.
- Reset mid-run: rst_n low during RUN -> Q=0, busy=0, done=0, tc=0 immediately (no clock needed). Start after release -> normal run from 0.
- Sticky tc (build with TFF_SEQ_TC_STICKY_EN): up from 9, mod_val=10, steps=3 -> tc stays high after the wrap through DONE and IDLE, and clears on the next accepted start. Without the macro, tc is high exactly one cycle.
